// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, P-register flag indices, FSM state type and the binary ALU datapath for alu_seq.
// Opcode and flag encodings are shared with the proc core and must stay in step with it.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_SL  = 3'd5;
    localparam logic [2:0] OP_SR  = 3'd6;
    localparam logic [2:0] OP_INC = 3'd7;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_OVERFLOW = 6;
    localparam int FLAG_SIGN     = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADJ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] y;
        logic       c;
        logic       v;
        logic       half;
    } alu_res_t;

    function automatic logic [7:0] make_flags(input logic [7:0] y, input logic v, input logic c);
        logic [7:0] f;
        f                = '0;
        f[FLAG_SIGN]     = y[7];
        f[FLAG_OVERFLOW] = v;
        f[FLAG_ZERO]     = (y == 8'h00);
        f[FLAG_CARRY]    = c;
        return f;
    endfunction

    function automatic alu_res_t alu_bin(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        alu_res_t   r;
        logic [7:0] bb;
        logic [8:0] s;
        r  = '0;
        bb = (op == OP_SUB) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
        case (op)
            OP_ADD, OP_SUB: begin
                r.y    = s[7:0];
                r.c    = s[8];
                r.v    = (a[7] == bb[7]) && (s[7] != a[7]);
                // carry into bit 4 recovered from the sum bits
                r.half = a[4] ^ bb[4] ^ s[4];
            end
            OP_AND: begin
                r.y = a & b;
                r.v = b[6];
            end
            OP_OR:  r.y = a | b;
            OP_EOR: r.y = a ^ b;
            OP_SL: begin
                r.y = {a[6:0], cin};
                r.c = a[7];
            end
            OP_SR: begin
                r.y = {cin, a[7:1]};
                r.c = a[0];
            end
            OP_INC: r.y = a + 8'd1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bcd_adjust.sv
// Decimal correction of a binary ADD/SUB intermediate: per-nibble +6 (ADD) or -6 (SUB).
// Purely combinational; used by alu_seq only when ALU_BCD_EN is defined.
module alu_bcd_adjust (
    input  logic [7:0] sum,
    input  logic       half,
    input  logic       carry,
    input  logic       sub,
    output logic [7:0] y,
    output logic       c
);

    logic       lo_adj;
    logic       hi_adj;
    logic [8:0] t;

    always_comb begin
        lo_adj = 1'b0;
        hi_adj = 1'b0;
        t      = {1'b0, sum};
        y      = sum;
        c      = carry;
        if (!sub) begin
            lo_adj = half || (sum[3:0] > 4'd9);
            t      = {1'b0, sum} + (lo_adj ? 9'h006 : 9'h000);
            // the low fix-up can push the high nibble past 9 or out of the byte
            hi_adj = carry || t[8] || (t[7:4] > 4'd9);
            y      = t[7:0] + (hi_adj ? 8'h60 : 8'h00);
            c      = hi_adj;
        end else begin
            lo_adj = !half;
            hi_adj = !carry;
            y      = sum - (lo_adj ? 8'h06 : 8'h00) - (hi_adj ? 8'h60 : 8'h00);
            c      = carry;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/valid handshake downstream of proc; binary ops take 1 cycle.
// Macro ALU_BCD_EN adds decimal ADD/SUB through an extra ADJ cycle; without it alu_BCD is ignored.
//   state   | meaning
//   IDLE    | accepting alu_start; binary results complete here
//   ADJ     | decimal correction of the captured binary sum, alu_busy high
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int RESULT_HOLD = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       alu_start,
    input  logic [2:0] alu_ctrl,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry,
    input  logic       alu_BCD,
    output logic [7:0] alu_Y,
    output logic [7:0] alu_flags,
    output logic       alu_valid,
    output logic       alu_busy
);

    state_t     state;
    logic [7:0] y_q;
    logic [7:0] flags_q;
    logic       valid_q;
    alu_res_t   res;

    assign res = alu_bin(alu_ctrl, alu_AI, alu_BI, alu_carry);

`ifdef ALU_BCD_EN
    logic [7:0] sum_q;
    logic       half_q;
    logic       carry_q;
    logic       sub_q;
    logic       v_q;
    logic       busy_q;
    logic       is_dec;
    logic [7:0] adj_y;
    logic       adj_c;

    assign is_dec = alu_BCD && ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB));

    alu_bcd_adjust u_adj (
        .sum   (sum_q),
        .half  (half_q),
        .carry (carry_q),
        .sub   (sub_q),
        .y     (adj_y),
        .c     (adj_c)
    );

    assign alu_busy = busy_q;
`else
    logic unused_bcd;
    assign unused_bcd = alu_BCD ^ res.half;
    assign alu_busy   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            y_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
`ifdef ALU_BCD_EN
            sum_q   <= '0;
            half_q  <= 1'b0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (alu_start) begin
`ifdef ALU_BCD_EN
                        if (is_dec) begin
                            sum_q   <= res.y;
                            half_q  <= res.half;
                            carry_q <= res.c;
                            sub_q   <= (alu_ctrl == OP_SUB);
                            v_q     <= res.v;
                            busy_q  <= 1'b1;
                            state   <= ST_ADJ;
                        end else
`endif
                        begin
                            y_q     <= res.y;
                            flags_q <= make_flags(res.y, res.v, res.c);
                            valid_q <= 1'b1;
                        end
                    end
                end
`ifdef ALU_BCD_EN
                ST_ADJ: begin
                    // alu_start is deliberately ignored here; proc must wait for valid
                    y_q     <= adj_y;
                    flags_q <= make_flags(adj_y, v_q, adj_c);
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_valid = valid_q;
    assign alu_Y     = ((RESULT_HOLD != 0) || valid_q) ? y_q : 8'h00;
    assign alu_flags = ((RESULT_HOLD != 0) || valid_q) ? flags_q : 8'h00;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: drives on the falling edge, checks on the next falling edge.
// Decimal-mode steps are selected by ALU_BCD_EN, matching the build of the design.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       alu_start;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry;
    logic       alu_BCD;
    logic [7:0] alu_Y;
    logic [7:0] alu_flags;
    logic       alu_valid;
    logic       alu_busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.RESULT_HOLD(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .alu_start (alu_start),
        .alu_ctrl  (alu_ctrl),
        .alu_AI    (alu_AI),
        .alu_BI    (alu_BI),
        .alu_carry (alu_carry),
        .alu_BCD   (alu_BCD),
        .alu_Y     (alu_Y),
        .alu_flags (alu_flags),
        .alu_valid (alu_valid),
        .alu_busy  (alu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic bcd);
        alu_start = st;
        alu_ctrl  = op;
        alu_AI    = a;
        alu_BI    = b;
        alu_carry = c;
        alu_BCD   = bcd;
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_y",     alu_Y,     8'h00);
        chk("rst_flags", alu_flags, 8'h00);
        chk("rst_valid", {7'd0, alu_valid}, 8'h00);
        chk("rst_busy",  {7'd0, alu_busy},  8'h00);
        resetn = 1'b1;
        @(negedge clk);

        // ADD 0x50+0x50: signed overflow into negative
        drive(1'b1, 3'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_valid", {7'd0, alu_valid}, 8'h01);
        chk("add_y",     alu_Y,     8'hA0);
        chk("add_flags", alu_flags, 8'hC0);

        // back-to-back: SUB 0x00-0x01 issued on the valid cycle
        drive(1'b1, 3'd1, 8'h00, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        chk("sub_valid", {7'd0, alu_valid}, 8'h01);
        chk("sub_y",     alu_Y,     8'hFF);
        chk("sub_flags", alu_flags, 8'h80);

        // AND 0xF0&0x40 back-to-back; V mirrors BI[6]
        drive(1'b1, 3'd2, 8'hF0, 8'h40, 1'b0, 1'b0);
        @(negedge clk);
        chk("and_valid", {7'd0, alu_valid}, 8'h01);
        chk("and_y",     alu_Y,     8'h40);
        chk("and_flags", alu_flags, 8'h40);

        drive(1'b0, 3'd0, 8'h11, 8'h22, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle_valid", {7'd0, alu_valid}, 8'h00);
        chk("hold_y",     alu_Y,     8'h40);

        drive(1'b1, 3'd5, 8'h80, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("sl_y",     alu_Y,     8'h00);
        chk("sl_flags", alu_flags, 8'h03);

        drive(1'b1, 3'd6, 8'h01, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("sr_y",     alu_Y,     8'h80);
        chk("sr_flags", alu_flags, 8'h81);

        drive(1'b1, 3'd7, 8'hFF, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("inc_y",     alu_Y,     8'h00);
        chk("inc_flags", alu_flags, 8'h02);

        drive(1'b1, 3'd3, 8'h0F, 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        chk("or_y",     alu_Y,     8'h3F);
        chk("or_flags", alu_flags, 8'h00);

        drive(1'b1, 3'd4, 8'hFF, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        chk("eor_y",     alu_Y,     8'hF0);
        chk("eor_flags", alu_flags, 8'h80);

        // binary ADD with carry out, BCD off: 0xFF+0x01+1
        drive(1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        chk("addc_y",     alu_Y,     8'h01);
        chk("addc_flags", alu_flags, 8'h01);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

`ifdef ALU_BCD_EN
        // BCD ADD 58+46+1 = 105; a start during busy must be dropped
        drive(1'b1, 3'd0, 8'h58, 8'h46, 1'b1, 1'b1);
        @(negedge clk);
        chk("bcda_busy",  {7'd0, alu_busy},  8'h01);
        chk("bcda_nov",   {7'd0, alu_valid}, 8'h00);
        drive(1'b1, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        chk("bcda_valid", {7'd0, alu_valid}, 8'h01);
        chk("bcda_nbusy", {7'd0, alu_busy},  8'h00);
        chk("bcda_y",     alu_Y,     8'h05);
        chk("bcda_flags", alu_flags, 8'h41);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("bcda_drop", {7'd0, alu_valid}, 8'h00);
        chk("bcda_hold", alu_Y, 8'h05);

        // BCD SUB 46-12 = 34; operands changed after the start edge
        drive(1'b1, 3'd1, 8'h46, 8'h12, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h99, 8'h99, 1'b0, 1'b0);
        chk("bcds_busy", {7'd0, alu_busy},  8'h01);
        chk("bcds_nov",  {7'd0, alu_valid}, 8'h00);
        @(negedge clk);
        chk("bcds_valid", {7'd0, alu_valid}, 8'h01);
        chk("bcds_y",     alu_Y,     8'h34);
        chk("bcds_flags", alu_flags, 8'h01);

        // BCD SUB with borrow: 00-01 = 99, C=0
        drive(1'b1, 3'd1, 8'h00, 8'h01, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("bcdb_y",     alu_Y,     8'h99);
        chk("bcdb_flags", alu_flags, 8'h80);

        // reset while in ADJ: abandoned, no valid afterwards
        drive(1'b1, 3'd0, 8'h09, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rsta_busy", {7'd0, alu_busy}, 8'h01);
        resetn = 1'b0;
        @(negedge clk);
        chk("rsta_valid", {7'd0, alu_valid}, 8'h00);
        chk("rsta_nbusy", {7'd0, alu_busy},  8'h00);
        chk("rsta_y",     alu_Y,     8'h00);
        chk("rsta_flags", alu_flags, 8'h00);
        resetn = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | alu_valid;
            end
            chk("rsta_novalid", {7'd0, seen}, 8'h00);
        end
`else
        // decimal flag ignored: 0x09+0x01 stays binary, 1-cycle latency
        drive(1'b1, 3'd0, 8'h09, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("nbcd_valid", {7'd0, alu_valid}, 8'h01);
        chk("nbcd_busy",  {7'd0, alu_busy},  8'h00);
        chk("nbcd_y",     alu_Y,     8'h0A);
        chk("nbcd_flags", alu_flags, 8'h00);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstb_y",     alu_Y,     8'h00);
        chk("rstb_valid", {7'd0, alu_valid}, 8'h00);
        resetn = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
